// File: rtl/smc_feeder.sv
// -----------------------------------------------------------------------------
// smc_feeder
// Collects six serial operands and a mode, and presents them to the six-operand
// chooser as a frame sorted in descending order, with a valid/ready handshake.
// Each accepted beat is inserted into a sorted 6-entry buffer. The buffer
// therefore stays sorted after every beat, and the last beat needs no separate
// sort pass.
//
// Ports
//   clk        single clock, rising edge
//   rst        asynchronous reset, active high
//   in_valid   upstream beat valid
//   in_ready   block can accept a beat this cycle
//   in_mode    frame mode, sampled on the first beat of a frame only
//   in_data    unsigned operand, one per accepted beat
//   out_valid  sorted frame available (only while in HOLD)
//   out_ready  downstream accepts the frame
//   out_mode   mode captured for the current frame
//   n0..n5     frame operands sorted descending, n0 largest (registered)
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | empty buffer, waiting for the first beat of a frame
// LOAD  | 1..5 beats collected, inserting further beats
// HOLD  | 6 beats collected, frame presented until out_ready
// -----------------------------------------------------------------------------
module smc_feeder #(
  parameter int DW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    in_mode,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [1:0]    out_mode,
  output logic [DW-1:0] n0,
  output logic [DW-1:0] n1,
  output logic [DW-1:0] n2,
  output logic [DW-1:0] n3,
  output logic [DW-1:0] n4,
  output logic [DW-1:0] n5
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t        r_state;
  logic [2:0]    r_count;
  logic [DW-1:0] r_buf [6];
  logic [1:0]    r_out_mode;
  logic          r_in_ready;
  logic          r_out_valid;

  logic [5:0]    w_gt;
  logic [DW-1:0] w_ins [6];

  // The buffer is sorted descending, so w_gt has the form 0..01..1. The new
  // value lands in the first slot whose w_gt bit is set. Slots after it take
  // their left neighbour. Strict '>' places a new value after any equal
  // entries, which keeps ties stable. Empty slots hold 0, so a zero operand
  // that finds no slot still leaves the correct 0 in place.
  always_comb begin
    for (int j = 0; j < 6; j++) begin
      w_gt[j] = (in_data > r_buf[j]);
    end
    w_ins[0] = w_gt[0] ? in_data : r_buf[0];
    for (int j = 1; j < 6; j++) begin
      w_ins[j] = r_buf[j];
      if (w_gt[j]) begin
        w_ins[j] = w_gt[j-1] ? r_buf[j-1] : in_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_count     <= 3'd0;
      r_out_mode  <= 2'd0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      for (int j = 0; j < 6; j++) r_buf[j] <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_out_mode <= in_mode;
            r_buf      <= w_ins;
            r_count    <= 3'd1;
            r_state    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (in_valid) begin
            r_buf <= w_ins;
            if (r_count == 3'd5) begin
              r_count     <= 3'd6;
              r_state     <= ST_HOLD;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
            end else begin
              r_count <= r_count + 3'd1;
            end
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            r_state     <= ST_IDLE;
            r_count     <= 3'd0;
            r_out_mode  <= 2'd0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            for (int j = 0; j < 6; j++) r_buf[j] <= '0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_count     <= 3'd0;
          r_out_mode  <= 2'd0;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          for (int j = 0; j < 6; j++) r_buf[j] <= '0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_mode  = r_out_mode;
  assign n0 = r_buf[0];
  assign n1 = r_buf[1];
  assign n2 = r_buf[2];
  assign n3 = r_buf[3];
  assign n4 = r_buf[4];
  assign n5 = r_buf[5];

endmodule

// File: tb/tb_smc_feeder.sv
// -----------------------------------------------------------------------------
// tb_smc_feeder
// Directed test of smc_feeder. Inputs are driven and outputs sampled on the
// falling edge, and the DUT updates on the rising edge.
// -----------------------------------------------------------------------------
module tb_smc_feeder;

  localparam int DW = 10;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_mode;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [1:0]    out_mode;
  logic [DW-1:0] n0, n1, n2, n3, n4, n5;

  int n_checks = 0;
  int n_fail   = 0;

  smc_feeder #(.DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mode  (out_mode),
    .n0        (n0),
    .n1        (n1),
    .n2        (n2),
    .n3        (n3),
    .n4        (n4),
    .n5        (n5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_frame(input string tag, input int e0, input int e1, input int e2,
                             input int e3, input int e4, input int e5, input int emode);
    check_val({tag, " n0"}, 32'(n0), 32'(e0));
    check_val({tag, " n1"}, 32'(n1), 32'(e1));
    check_val({tag, " n2"}, 32'(n2), 32'(e2));
    check_val({tag, " n3"}, 32'(n3), 32'(e3));
    check_val({tag, " n4"}, 32'(n4), 32'(e4));
    check_val({tag, " n5"}, 32'(n5), 32'(e5));
    check_val({tag, " mode"}, 32'(out_mode), 32'(emode));
  endtask

  // The caller is at a falling edge. The task presents one beat, lets a
  // rising edge take it, and returns on the next falling edge.
  task automatic send_beat(input string tag, input int data, input int mode);
    check_val({tag, " in_ready"}, 32'(in_ready), 32'd1);
    check_val({tag, " out_valid low"}, 32'(out_valid), 32'd0);
    in_valid = 1'b1;
    in_data  = DW'(data);
    in_mode  = 2'(mode);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic handshake(input string tag);
    check_val({tag, " out_valid before hs"}, 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check_val({tag, " out_valid after hs"}, 32'(out_valid), 32'd0);
    check_val({tag, " in_ready after hs"}, 32'(in_ready), 32'd1);
    check_frame({tag, " cleared"}, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_mode   = 2'd0;
    in_data   = '0;
    out_ready = 1'b0;
    #2;
    // Reset state, checked before any clock edge.
    check_val("rst out_valid", 32'(out_valid), 32'd0);
    check_val("rst in_ready", 32'(in_ready), 32'd1);
    check_frame("rst", 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    idle_cycles(1);

    // out_ready is ignored outside HOLD.
    out_ready = 1'b1;
    idle_cycles(2);
    out_ready = 1'b0;
    check_val("idle ordy in_ready", 32'(in_ready), 32'd1);
    check_val("idle ordy out_valid", 32'(out_valid), 32'd0);

    // Back-to-back frame.
    send_beat("b2b b1", 14, 1);
    send_beat("b2b b2", 30, 0);
    send_beat("b2b b3", 3, 2);
    send_beat("b2b b4", 11, 3);
    send_beat("b2b b5", 1, 0);
    send_beat("b2b b6", 4, 0);
    check_val("b2b out_valid", 32'(out_valid), 32'd1);
    check_val("b2b in_ready", 32'(in_ready), 32'd0);
    check_frame("b2b", 30, 14, 11, 4, 3, 1, 1);

    // Backpressure in HOLD while upstream keeps offering beats.
    in_valid = 1'b1;
    in_data  = DW'(7);
    in_mode  = 2'd2;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_val("bp out_valid", 32'(out_valid), 32'd1);
      check_val("bp in_ready", 32'(in_ready), 32'd0);
      check_frame("bp", 30, 14, 11, 4, 3, 1, 1);
    end
    in_valid = 1'b0;
    handshake("bp");

    // Ties and extremes.
    send_beat("tie b1", 5, 2);
    send_beat("tie b2", 0, 0);
    send_beat("tie b3", 5, 0);
    send_beat("tie b4", 1023, 0);
    send_beat("tie b5", 0, 0);
    send_beat("tie b6", 5, 0);
    check_val("tie out_valid", 32'(out_valid), 32'd1);
    check_frame("tie", 1023, 5, 5, 5, 0, 0, 2);
    handshake("tie");

    // Input gaps; in_mode changes after the first beat are ignored.
    send_beat("gap b1", 9, 3);
    idle_cycles(3);
    check_val("gap hold n0", 32'(n0), 32'd9);
    send_beat("gap b2", 2, 0);
    send_beat("gap b3", 8, 0);
    idle_cycles(1);
    send_beat("gap b4", 6, 0);
    send_beat("gap b5", 1, 0);
    check_frame("gap partial", 9, 8, 6, 2, 1, 0, 3);
    send_beat("gap b6", 3, 0);
    check_val("gap out_valid", 32'(out_valid), 32'd1);
    check_frame("gap", 9, 8, 6, 3, 2, 1, 3);
    handshake("gap");

    // Reset mid-frame, asserted between edges.
    send_beat("mid b1", 100, 1);
    send_beat("mid b2", 200, 0);
    send_beat("mid b3", 300, 0);
    #2;
    rst = 1'b1;
    #1;
    check_val("mid rst out_valid", 32'(out_valid), 32'd0);
    check_val("mid rst in_ready", 32'(in_ready), 32'd1);
    check_frame("mid rst", 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 6; k++) send_beat("seq", k, (k == 1) ? 2 : 1);
    check_val("seq out_valid", 32'(out_valid), 32'd1);
    check_frame("seq", 6, 5, 4, 3, 2, 1, 2);

    // Reset while a frame is pending in HOLD.
    #2;
    rst = 1'b1;
    #1;
    check_val("hold rst out_valid", 32'(out_valid), 32'd0);
    check_val("hold rst in_ready", 32'(in_ready), 32'd1);
    check_frame("hold rst", 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    send_beat("post b1", 50, 1);
    check_frame("post", 50, 0, 0, 0, 0, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/smc_feeder.md
SMC_FEEDER -- requirements
Module: smc_feeder

Interface
REQ-001 Parameter DW, default 10, width of each data operand.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  upstream beat valid.
REQ-005 in_ready  output  1  block can accept a beat this cycle.
REQ-006 in_mode  input  2  selection mode; sampled only on the first beat of a frame.
REQ-007 in_data  input  DW  one unsigned operand per accepted beat.
REQ-008 out_valid  output  1  sorted frame available to downstream chooser.
REQ-009 out_ready  input  1  downstream accepts the frame.
REQ-010 out_mode  output  2  mode captured for the current frame.
REQ-011 n0..n5  output  DW each  frame operands sorted descending; n0 is largest.

Function
REQ-012 The block SHALL be the producer for the six-operand chooser: it collects six serial operands plus a mode and presents them in parallel with a valid/ready handshake.
REQ-013 A beat SHALL be accepted only on a rising edge with in_valid=1 and in_ready=1.
REQ-014 The FSM SHALL have states IDLE, LOAD and HOLD; the reset state is IDLE.
REQ-015 IDLE: in_ready=1, out_valid=0; on an accepted beat, capture in_mode into out_mode, insert in_data, set count=1, go to LOAD.
REQ-016 LOAD: in_ready=1, out_valid=0; insert each accepted in_data and increment count; in_mode ignored; on the 6th accepted beat go to HOLD.
REQ-017 Gaps (in_valid=0) in IDLE or LOAD SHALL hold all state unchanged; there is no timeout.
REQ-018 Insertion SHALL keep the 6-entry buffer sorted descending every cycle: the new value goes in at the first index i where in_data > buf[i], and entries i..4 shift down one place.
REQ-019 Ties SHALL be stable: a new value equal to existing entries is placed after them.
REQ-020 Empty buffer slots SHALL hold 0, so zero operands sort to the tail correctly.
REQ-021 n0..n5 SHALL be driven directly from buf[0..5] registers, with no combinational path from in_data.
REQ-022 out_valid SHALL be 1 exactly while in HOLD, first asserted the cycle after the 6th beat is accepted (latency 1).
REQ-023 HOLD: in_ready=0; in_valid ignored; n0..n5 and out_mode held stable until out_valid & out_ready.
REQ-024 On the HOLD handshake edge, the next state SHALL be IDLE with buffer, count and out_mode cleared to 0.
REQ-025 Consequently in_ready returns to 1 the cycle after the handshake, giving a minimum frame period of 7 cycles.
REQ-026 out_ready SHALL be ignored outside HOLD.
REQ-027 count SHALL be 3 bits and never exceed 6.

Reset
REQ-028 While rst=1, the block SHALL immediately (no clock needed) be in state IDLE with count=0, buf[0..5]=0 and out_mode=0.
REQ-029 During reset the outputs SHALL be out_valid=0, in_ready=1, n0..n5=0 and out_mode=0.
REQ-030 Reset asserted mid-LOAD or in HOLD SHALL discard the partial or pending frame.
REQ-031 After reset deasserts, the next accepted beat is treated as the first beat of a new frame.

Verification
REQ-032 Reset: assert rst asynchronously between edges -> n0..n5=0, out_valid=0, in_ready=1 without a clock edge.
REQ-033 Back-to-back load: beats 14,30,3,11,1,4 with in_mode=01 on the first beat -> one cycle after beat 6, out_valid=1, n0..n5=30,14,11,4,3,1, out_mode=01.
REQ-034 Ties/extremes: beats 5,0,5,1023,0,5 with mode 10 -> n0..n5=1023,5,5,5,0,0, out_mode=10.
REQ-035 Backpressure: hold out_ready=0 for 5 cycles in HOLD while driving in_valid=1, in_data=7 -> outputs unchanged and in_ready=0 throughout; then out_ready=1 for one cycle -> next cycle out_valid=0, in_ready=1, n0..n5=0.
REQ-036 Input gaps and mode change: beats 9,(gap 3 cycles),2,8,(gap),6,1,3, with in_mode=11 on the first beat and 00 on later beats -> n0..n5=9,8,6,3,2,1, out_mode=11.
REQ-037 Reset mid-frame: accept 3 beats, pulse rst, then load 1..6 -> n0..n5=6,5,4,3,2,1, with no residue from the earlier beats.
